// File: rtl/lt_axi_pkg.sv
// Shared types and constants for the loopback AXI3 responder: response/burst encodings,
// the queued read-request record and the write/read FSM states.
package lt_axi_pkg;

    localparam int unsigned AxiAddrW = 33;
    localparam int unsigned AxiIdW   = 5;
    localparam int unsigned AxiLenW  = 8;
    localparam int unsigned StampW   = 16;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [AxiLenW-1:0]  len;
        logic [1:0]          burst;
        logic [StampW-1:0]   stamp;
    } rd_req_t;

    typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;
    typedef enum logic [1:0] {RWait, RPrime, RBurst} rd_state_e;

    // Anything other than FIXED walks the index like INCR.
    function automatic logic is_fixed(input logic [1:0] burst);
        return burst == BurstFixed;
    endfunction

endpackage

// File: rtl/lt_axi_if.sv
// AXI3 bus bundle between a benchmark engine (master) and the loopback responder (slave).
interface lt_axi_if #(
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [LEN_WIDTH-1:0]    awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [ID_WIDTH-1:0]     wid;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [LEN_WIDTH-1:0]    arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [1:0]              arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rlast;
    logic [ID_WIDTH-1:0]     rid;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awregion,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wid,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
               arregion,
        input  arready,
        input  rvalid, rdata, rlast, rid, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awregion,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wid,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
               arregion,
        output arready,
        output rvalid, rdata, rlast, rid, rresp,
        input  rready
    );

endinterface

// File: rtl/lt_req_fifo.sv
// Synchronous FIFO of queued read requests; a push while full is accepted only if the
// head is popped in the same cycle.
module lt_req_fifo
    import lt_axi_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  rd_req_t data_i,
    input  logic    pop_i,
    output rd_req_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    rd_req_t         mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = cnt_q == CntW'(Depth);
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lt_axi_responder.sv
// AXI3 slave that stands in for one memory channel: stores writes in a word memory and
// answers reads after a fixed minimum latency so engine latency sums are deterministic.
module lt_axi_responder
    import lt_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RD_LATENCY = 16
) (
    input  logic        clk,
    input  logic        rst,
    lt_axi_if.slave     axi,
    output logic [31:0] wr_bursts,
    output logic [31:0] rd_bursts
);

    localparam int unsigned BeatBytes = DATA_WIDTH / 8;
    localparam int unsigned OffW      = $clog2(BeatBytes);
    localparam int unsigned MemDepth  = 2 ** MEM_AW;
    localparam int unsigned FifoDepth = 4;
    localparam logic [StampW-1:0] RdLat = StampW'(RD_LATENCY);

    typedef logic [MEM_AW-1:0] idx_t;

    logic [DATA_WIDTH-1:0] mem_q [MemDepth];

    // ---------------------------------------------------------------- write path
    wr_state_e             wstate_q, wstate_d;
    idx_t                  widx_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [LEN_WIDTH-1:0]  wlen_q, wbeat_q;
    logic                  wfixed_q, werr_q;
    logic [31:0]           wr_cnt_q;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  aw_hs, w_hs, b_hs, w_last_beat;

    assign aw_addr     = axi.awaddr;
    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign b_hs        = axi.bvalid && axi.bready;
    assign w_last_beat = wbeat_q == wlen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= WIdle;
        end else begin
            wstate_q <= wstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        unique case (wstate_q)
            WIdle:   if (aw_hs) wstate_d = WData;
            WData:   if (w_hs && w_last_beat) wstate_d = WResp;
            WResp:   if (b_hs) wstate_d = WIdle;
            default: wstate_d = WIdle;
        endcase
    end

    always_comb begin
        axi.awready = (wstate_q == WIdle) && !rst;
        axi.wready  = wstate_q == WData;
        axi.bvalid  = wstate_q == WResp;
        axi.bresp   = werr_q ? RespSlvErr : RespOkay;
        axi.bid     = wid_q;
    end

    // WLAST is only audited; the beat count alone closes the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q   <= '0;
            wid_q    <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            wfixed_q <= 1'b0;
            werr_q   <= 1'b0;
        end else if (aw_hs) begin
            widx_q   <= aw_addr[MEM_AW+OffW-1:OffW];
            wid_q    <= axi.awid;
            wlen_q   <= axi.awlen;
            wbeat_q  <= '0;
            wfixed_q <= is_fixed(axi.awburst);
            werr_q   <= 1'b0;
        end else if (w_hs) begin
            wbeat_q <= wbeat_q + 1'b1;
            widx_q  <= wfixed_q ? widx_q : widx_q + 1'b1;
            werr_q  <= werr_q | (axi.wlast != w_last_beat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
        end else if (b_hs) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < int'(BeatBytes); b++) begin
                if (axi.wstrb[b]) begin
                    mem_q[widx_q][b*8 +: 8] <= axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read path
    rd_state_e             rstate_q, rstate_d;
    rd_req_t               push_req, head;
    logic                  fifo_full, fifo_empty, pop, head_ready;
    logic [StampW-1:0]     cyc_q, age;
    logic [ADDR_WIDTH-1:0] ar_addr;
    idx_t                  ridx_q, ridx_next, rd_addr;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [LEN_WIDTH-1:0]  rlen_q, rbeat_q;
    logic                  rfixed_q, r_hs, r_last, rd_en;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [31:0]           rd_cnt_q;
    logic                  ar_hs;

    assign ar_addr = axi.araddr;
    assign ar_hs   = axi.arvalid && axi.arready;

    always_comb begin
        push_req.id    = AxiIdW'(axi.arid);
        push_req.addr  = AxiAddrW'(ar_addr);
        push_req.len   = AxiLenW'(axi.arlen);
        push_req.burst = axi.arburst;
        push_req.stamp = cyc_q;
    end

    lt_req_fifo #(
        .Depth (FifoDepth)
    ) u_req_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (ar_hs),
        .data_i  (push_req),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Modular age keeps the comparison correct across counter wrap.
    assign age        = cyc_q - head.stamp;
    assign head_ready = !fifo_empty && (age >= RdLat);
    assign pop        = (rstate_q == RWait) && head_ready;
    assign r_hs       = axi.rvalid && axi.rready;
    assign r_last     = rbeat_q == rlen_q;
    assign ridx_next  = rfixed_q ? ridx_q : ridx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= RWait;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            RWait:   if (head_ready) rstate_d = RPrime;
            RPrime:  rstate_d = RBurst;
            RBurst:  if (r_hs && r_last) rstate_d = RWait;
            default: rstate_d = RWait;
        endcase
    end

    always_comb begin
        axi.arready = !fifo_full && !rst;
        axi.rvalid  = rstate_q == RBurst;
        axi.rdata   = rdata_q;
        axi.rlast   = (rstate_q == RBurst) && r_last;
        axi.rid     = rid_q;
        axi.rresp   = RespOkay;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ridx_q   <= '0;
            rid_q    <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rfixed_q <= 1'b0;
        end else if (pop) begin
            ridx_q   <= head.addr[MEM_AW+OffW-1:OffW];
            rid_q    <= ID_WIDTH'(head.id);
            rlen_q   <= LEN_WIDTH'(head.len);
            rbeat_q  <= '0;
            rfixed_q <= is_fixed(head.burst);
        end else if (r_hs && !r_last) begin
            rbeat_q <= rbeat_q + 1'b1;
            ridx_q  <= ridx_next;
        end
    end

    // The next beat is fetched only on a handshake, so RDATA holds under backpressure.
    assign rd_en   = (rstate_q == RPrime) || (r_hs && !r_last);
    assign rd_addr = (rstate_q == RPrime) ? ridx_q : ridx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else if (r_hs && r_last) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_bursts = wr_cnt_q;
    assign rd_bursts = rd_cnt_q;

    logic unused_ok;
    assign unused_ok = ^{aw_addr, ar_addr, head.addr, axi.awsize, axi.awlock, axi.awcache,
                         axi.awprot, axi.awqos, axi.awregion, axi.wid, axi.arsize, axi.arlock,
                         axi.arcache, axi.arprot, axi.arqos, axi.arregion};

endmodule

// File: tb/tb_lt_axi_responder.sv
// Directed bench for lt_axi_responder with a word-memory model and R/B scoreboards.
module tb_lt_axi_responder;
    import lt_axi_pkg::*;

    localparam int unsigned DW  = 256;
    localparam int unsigned AW  = 33;
    localparam int unsigned IW  = 5;
    localparam int unsigned LW  = 8;
    localparam int unsigned MAW = 10;
    localparam int unsigned LAT = 16;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } rbeat_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } bexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wr_bursts, rd_bursts;
    int unsigned cyc = 0;
    int          n_checks = 0, n_pass = 0, n_fail = 0;
    int unsigned exp_wr = 0, exp_rd = 0;
    int unsigned t_ar;

    logic [DW-1:0] model [int];
    rbeat_t        rq [$];
    bexp_t         bq [$];

    lt_axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) axi ();

    lt_axi_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW),
        .MEM_AW     (MAW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi),
        .wr_bursts (wr_bursts),
        .rd_bursts (rd_bursts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: compare every valid beat against the queue head.
    always @(negedge clk) begin
        if (!rst && axi.rvalid) begin
            if (rq.size() == 0) begin
                check("r_unexpected", DW'(axi.rvalid), '0);
            end else begin
                check("rid", DW'(axi.rid), DW'(rq[0].id));
                check("rdata", axi.rdata, rq[0].data);
                check("rlast", DW'(axi.rlast), DW'(rq[0].last));
                check("rresp", DW'(axi.rresp), DW'(RespOkay));
                if (axi.rready) void'(rq.pop_front());
            end
        end
        if (!rst && axi.bvalid && axi.bready) begin
            if (bq.size() == 0) begin
                check("b_unexpected", DW'(axi.bvalid), '0);
            end else begin
                check("bid", DW'(axi.bid), DW'(bq[0].id));
                check("bresp", DW'(axi.bresp), DW'(bq[0].resp));
                void'(bq.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // bad_last < 0: WLAST on the final beat only; otherwise WLAST only on beat bad_last.
    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [1:0] burst, input logic [IW-1:0] id,
                            input logic [DW-1:0] fill, input bit rnd,
                            input logic [DW/8-1:0] strb, input int bad_last);
        int            g = 0;
        logic [MAW-1:0] idx;
        logic [DW-1:0]  d, m;
        bexp_t          be;
        idx     = addr[MAW+4:5];
        be.id   = id;
        be.resp = (bad_last >= 0 && bad_last != int'(len)) ? RespSlvErr : RespOkay;
        bq.push_back(be);
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        axi.awid    = id;
        axi.awlen   = len;
        axi.awburst = burst;
        while (!axi.awready && g < 50) begin tick(); g++; end
        check("aw_accept", DW'(axi.awready), DW'(1));
        tick();
        axi.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            check("wready_beat", DW'(axi.wready), DW'(1));
            d = rnd ? rand_beat() : fill;
            axi.wvalid = 1'b1;
            axi.wdata  = d;
            axi.wstrb  = strb;
            axi.wlast  = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
            m = model.exists(int'(idx)) ? model[int'(idx)] : '0;
            for (int k = 0; k < int'(DW / 8); k++) if (strb[k]) m[k*8 +: 8] = d[k*8 +: 8];
            model[int'(idx)] = m;
            tick();
            if (burst != BurstFixed) idx++;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        check("bvalid_u1", DW'(axi.bvalid), DW'(1));
        tick();
        exp_wr++;
        check("bvalid_drop", DW'(axi.bvalid), '0);
        check("wr_bursts", DW'(wr_bursts), DW'(exp_wr));
    endtask

    task automatic issue_ar(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [1:0] burst, input logic [IW-1:0] id,
                            output int unsigned t);
        int             g = 0;
        logic [MAW-1:0] idx;
        rbeat_t         e;
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        axi.arid    = id;
        axi.arlen   = len;
        axi.arburst = burst;
        while (!axi.arready && g < 100) begin tick(); g++; end
        check("ar_accept", DW'(axi.arready), DW'(1));
        t   = cyc;
        idx = addr[MAW+4:5];
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.data = model[int'(idx)];
            e.last = (b == int'(len));
            rq.push_back(e);
            if (burst != BurstFixed) idx++;
        end
        tick();
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        int g = 0;
        while (!axi.rvalid && g < 200) begin tick(); g++; end
        check("rvalid_seen", DW'(axi.rvalid), DW'(1));
    endtask

    task automatic wait_drain();
        int g = 0;
        while (rq.size() != 0 && g < 500) begin tick(); g++; end
        check("r_drained", DW'(rq.size()), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned ts;
        logic [3:0]  pat;
        axi.awvalid = 0; axi.awaddr = '0; axi.awid = '0; axi.awlen = '0; axi.awsize = 3'd5;
        axi.awburst = BurstIncr; axi.awlock = '0; axi.awcache = '0; axi.awprot = '0;
        axi.awqos = '0; axi.awregion = '0;
        axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0; axi.wid = '0;
        axi.bready = 1;
        axi.arvalid = 0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0; axi.arsize = 3'd5;
        axi.arburst = BurstIncr; axi.arlock = '0; axi.arcache = '0; axi.arprot = '0;
        axi.arqos = '0; axi.arregion = '0;
        axi.rready = 0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", DW'(axi.awready), '0);
        check("rst_arready", DW'(axi.arready), '0);
        check("rst_bvalid", DW'(axi.bvalid), '0);
        check("rst_rvalid", DW'(axi.rvalid), '0);
        check("rst_wr_bursts", DW'(wr_bursts), '0);
        check("rst_rd_bursts", DW'(rd_bursts), '0);
        rst = 0;
        #1;
        check("post_rst_awready", DW'(axi.awready), DW'(1));
        check("post_rst_arready", DW'(axi.arready), DW'(1));

        // Single write, then partial-strobe overwrite
        do_write(33'h40, 8'd0, BurstIncr, 5'd3, {32{8'hA5}}, 1'b0, '1, -1);
        do_write(33'h60, 8'd0, BurstIncr, 5'd4, '0, 1'b1, '1, -1);
        do_write(33'h60, 8'd0, BurstIncr, 5'd5, '0, 1'b1, 32'h0000_FFFF, -1);

        // Burst write, then streaming read with latency check
        do_write(33'h0, 8'd3, BurstIncr, 5'd7, '0, 1'b1, '1, -1);
        axi.rready = 1;
        issue_ar(33'h0, 8'd3, BurstIncr, 5'd9, t_ar);
        wait_rvalid();
        check("rvalid_latency", DW'(cyc - t_ar), DW'(LAT + 2));
        repeat (4) tick();
        check("r_stream_4", DW'(rq.size()), '0);
        check("rvalid_after", DW'(axi.rvalid), '0);
        exp_rd++;
        check("rd_bursts_1", DW'(rd_bursts), DW'(exp_rd));

        // Backpressure: RREADY 1,0,0,1
        axi.rready = 0;
        issue_ar(33'h0, 8'd3, BurstIncr, 5'd10, t_ar);
        wait_rvalid();
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            axi.rready = pat[i];
            if (!pat[i]) check("rvalid_hold", DW'(axi.rvalid), DW'(1));
            tick();
        end
        axi.rready = 1;
        wait_drain();
        exp_rd++;
        check("rd_bursts_stall", DW'(rd_bursts), DW'(exp_rd));

        // Misplaced WLAST: still four beats, SLVERR
        do_write(33'h100, 8'd3, BurstIncr, 5'd11, '0, 1'b1, '1, 2);

        // Index wrap at top of memory, aliasing upper address bits, FIXED burst
        do_write(33'h7FE0, 8'd1, BurstIncr, 5'd12, '0, 1'b1, '1, -1);
        issue_ar(33'h7FE0, 8'd1, BurstIncr, 5'd13, t_ar);
        wait_drain();
        issue_ar(33'h1_0000_0040, 8'd2, BurstFixed, 5'd14, t_ar);
        wait_drain();
        exp_rd += 2;
        check("rd_bursts_wrap", DW'(rd_bursts), DW'(exp_rd));

        // Five back-to-back ARs with RREADY low
        axi.rready = 0;
        for (int i = 0; i < 4; i++) issue_ar(33'(i * 32), 8'd1, BurstIncr, 5'(16 + i), ts);
        check("arready_full", DW'(axi.arready), '0);
        issue_ar(33'h100, 8'd1, BurstIncr, 5'd20, ts);
        axi.rready = 1;
        wait_drain();
        exp_rd += 5;
        check("rd_bursts_5", DW'(rd_bursts), DW'(exp_rd));

        // Reset in the middle of a read burst
        axi.rready = 0;
        issue_ar(33'h0, 8'd3, BurstIncr, 5'd21, t_ar);
        wait_rvalid();
        axi.rready = 1;
        tick();
        rst = 1;
        axi.rready = 0;
        tick();
        check("midrst_rvalid", DW'(axi.rvalid), '0);
        check("midrst_arready", DW'(axi.arready), '0);
        check("midrst_wr_bursts", DW'(wr_bursts), '0);
        check("midrst_rd_bursts", DW'(rd_bursts), '0);
        rq.delete();
        exp_wr = 0;
        exp_rd = 0;
        rst = 0;
        #1;
        check("midrst_awready_up", DW'(axi.awready), DW'(1));
        axi.rready = 1;
        issue_ar(33'h40, 8'd0, BurstIncr, 5'd22, t_ar);
        wait_rvalid();
        check("post_rst_latency", DW'(cyc - t_ar), DW'(LAT + 2));
        wait_drain();
        exp_rd++;
        check("post_rst_rd_bursts", DW'(rd_bursts), DW'(exp_rd));

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
